// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one synchronous-SRAM memory port between two requesters
//            (port 0 = multicycle core, port 1 = DMA/debug loader).
//            Round-robin arbitration with an optional bounded burst lock;
//            one transaction in flight at a time.
// Ports    : clk_in, rst_in          - clock, synchronous active-high reset
//            mX_req/we/lock          - request, write select, keep-priority
//            mX_addr/mX_wdata        - byte address and write data
//            mX_gnt                  - pulse: access is on the memory port
//            mX_rvalid/mX_rdata      - pulse + read data (0 when not valid)
//            address/data_out        - memory address and write data
//            r_en_mem/w_en_mem       - memory read / write strobes
//            MemData                 - memory read data
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int MEM_LAT  = 1,   // r_en_mem cycle to MemData valid, 1..4
  parameter int MAX_HOLD = 8    // max consecutive locked grants, 1..15
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] address,
  output logic [31:0] data_out,
  output logic        r_en_mem,
  output logic        w_en_mem,
  input  logic [31:0] MemData
);

  localparam int c_HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int c_WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [c_HOLD_W-1:0] c_HOLD_MAX  = c_HOLD_W'(MAX_HOLD);
  localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_LOAD = c_WAIT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_sel;        // port owning the current transaction
  logic                r_last_gnt;   // most recent winner
  logic [c_HOLD_W-1:0] r_hold_cnt;   // consecutive grants to r_last_gnt
  logic [c_WAIT_W-1:0] r_wait_cnt;   // cycles left until MemData is valid

  logic                w_win_valid;
  logic                w_win;
  logic                w_last_req;
  logic                w_last_lock;
  logic                w_sel_we;

  // --------------------------------------------------------------------------
  // Winner selection. Only the last grantee's lock counts; a lock from the
  // other port is meaningless because that port already wins the tie.
  // --------------------------------------------------------------------------
  assign w_last_req  = r_last_gnt ? m1_req  : m0_req;
  assign w_last_lock = r_last_gnt ? m1_lock : m0_lock;

  always_comb begin
    w_win_valid = m0_req | m1_req;
    w_win       = 1'b0;
    if (w_last_req && w_last_lock && (r_hold_cnt < c_HOLD_MAX)) begin
      w_win = r_last_gnt;
    end else if (m0_req && m1_req) begin
      w_win = ~r_last_gnt;
    end else if (m1_req) begin
      w_win = 1'b1;
    end
  end

  assign w_sel_we = r_sel ? m1_we : m0_we;

  // --------------------------------------------------------------------------
  // State and arbitration registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_sel      <= 1'b0;
      r_last_gnt <= 1'b1;            // port 0 wins the first contention
      r_hold_cnt <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;

      if ((r_state == S_IDLE) && w_win_valid) begin
        r_sel      <= w_win;
        r_last_gnt <= w_win;
        if (w_win == r_last_gnt) begin
          // Saturate so a long unopposed lock cannot wrap back to eligible.
          if (r_hold_cnt != c_HOLD_MAX) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end else begin
          r_hold_cnt <= c_HOLD_ONE;
        end
      end

      if (r_state == S_ISSUE) begin
        r_wait_cnt <= c_WAIT_LOAD;
      end else if ((r_state == S_WAIT) && (r_wait_cnt != '0)) begin
        r_wait_cnt <= r_wait_cnt - 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs. Everything is zero outside ISSUE, except the
  // read-data pulse in the final WAIT cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    address     = '0;
    data_out    = '0;
    r_en_mem    = 1'b0;
    w_en_mem    = 1'b0;
    m0_gnt      = 1'b0;
    m1_gnt      = 1'b0;
    m0_rvalid   = 1'b0;
    m1_rvalid   = 1'b0;
    m0_rdata    = '0;
    m1_rdata    = '0;

    case (r_state)
      S_IDLE: begin
        if (w_win_valid) begin
          w_state_nxt = S_ISSUE;
        end
      end

      S_ISSUE: begin
        // Issues unconditionally: a request dropped after selection still goes.
        address     = r_sel ? m1_addr  : m0_addr;
        data_out    = r_sel ? m1_wdata : m0_wdata;
        w_en_mem    = w_sel_we;
        r_en_mem    = ~w_sel_we;
        m0_gnt      = ~r_sel;
        m1_gnt      = r_sel;
        w_state_nxt = w_sel_we ? S_IDLE : S_WAIT;
      end

      S_WAIT: begin
        if (r_wait_cnt == '0) begin
          m0_rvalid   = ~r_sel;
          m1_rvalid   = r_sel;
          m0_rdata    = r_sel ? '0 : MemData;
          m1_rdata    = r_sel ? MemData : '0;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
